// File: rtl/beam_pulse_gen.sv
// Photo-beam conditioner: two independent channels, each synchronised, debounced and
// edge-qualified into an active-low single-cycle count pulse, plus a stuck-blocked fault.

module beam_pulse_chan #(
    parameter int DB_CYCLES    = 4,
    parameter int STUCK_CYCLES = 64,
    parameter int CW           = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beam,
    input  logic       gate,
    output logic       pulse_n,
    output logic       stuck,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        CLEAR    = 3'd0,
        ARM_LOW  = 3'd1,
        BLOCKED  = 3'd2,
        ARM_HIGH = 3'd3,
        STUCK    = 3'd4
    } state_t;

    localparam logic [CW-1:0] DB_C    = CW'(DB_CYCLES);
    localparam logic [CW-1:0] STUCK_C = CW'(STUCK_CYCLES);

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic          pulse_n_q, pulse_n_d;
    logic          stuck_q, stuck_d;
    logic          s;
    logic          fire;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        sync1_d = beam;
        sync2_d = sync1_q;
        s       = sync2_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        fire    = 1'b0;
        case (state_q)
            CLEAR: begin
                if (!s) begin
                    state_d = ARM_LOW;
                    cnt_d   = CW'(1);
                end
            end
            ARM_LOW: begin
                if (s) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_C) begin
                    state_d = BLOCKED;
                    cnt_d   = '0;
                    dwell_d = '0;
                    fire    = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            BLOCKED: begin
                if (s) begin
                    state_d = ARM_HIGH;
                    cnt_d   = CW'(1);
                end else begin
                    dwell_d = sat_inc(dwell_q);
                    if (dwell_d >= STUCK_C) begin
                        state_d = STUCK;
                        cnt_d   = '0;
                    end
                end
            end
            // A low sample here is release bounce: resume BLOCKED with the dwell count intact.
            ARM_HIGH: begin
                if (!s) begin
                    state_d = BLOCKED;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_C) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            STUCK: begin
                if (!s) begin
                    cnt_d = '0;
                end else if (sat_inc(cnt_q) >= DB_C) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    dwell_d = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                dwell_d = '0;
            end
        endcase
        pulse_n_d = ~(fire & ~gate);
        stuck_d   = (state_d == STUCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= CLEAR;
            cnt_q     <= '0;
            dwell_q   <= '0;
            pulse_n_q <= 1'b1;
            stuck_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dwell_q   <= dwell_d;
            pulse_n_q <= pulse_n_d;
            stuck_q   <= stuck_d;
        end
    end

    assign pulse_n   = pulse_n_q;
    assign stuck     = stuck_q;
    assign state_dbg = state_q;
endmodule

module beam_pulse_gen #(
    parameter int DB_CYCLES    = 4,
    parameter int STUCK_CYCLES = 64,
    parameter int CW           = 7
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       FBeam,
    input  logic       BBeam,
    input  logic       full_flag,
    input  logic       empty_flag,
    output logic       up_count,
    output logic       down_count,
    output logic       f_stuck,
    output logic       b_stuck,
    output logic [2:0] b_state,
    output logic [2:0] f_state
);
    // Arrivals are dropped when the queue is full, departures when it is empty.
    beam_pulse_chan #(.DB_CYCLES(DB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES), .CW(CW)) u_b_chan (
        .clk(clk), .rst(Reset), .beam(BBeam), .gate(full_flag),
        .pulse_n(up_count), .stuck(b_stuck), .state_dbg(b_state)
    );

    beam_pulse_chan #(.DB_CYCLES(DB_CYCLES), .STUCK_CYCLES(STUCK_CYCLES), .CW(CW)) u_f_chan (
        .clk(clk), .rst(Reset), .beam(FBeam), .gate(empty_flag),
        .pulse_n(down_count), .stuck(f_stuck), .state_dbg(f_state)
    );
endmodule

// File: doc/beam_pulse_gen.md
Name: beam_pulse_gen

Overview:
Upstream front-end of the single-bank queue manager. Conditions the two raw photo-beam sensors, FBeam at the teller end and BBeam at the queue entry. Each sensor is synchronised, debounced and edge-qualified into a single-cycle count pulse: BBeam drives up_count and FBeam drives down_count on the queue manager. The block also suppresses pulses the queue cannot accept and flags a beam that stays blocked too long.

Parameters:
DB_CYCLES, 4, consecutive synchronised samples needed to accept a beam level change; legal range 1..15.
STUCK_CYCLES, 64, cycles spent in BLOCKED before the beam is declared stuck; must exceed DB_CYCLES.
CW, 7, width of each per-channel cycle counter; must satisfy 2^CW > STUCK_CYCLES.

Ports:
clk  in  1  system clock; all logic on the rising edge
Reset  in  1  synchronous, active-high reset
FBeam  in  1  raw front-beam sensor, asynchronous; 0 = broken, 1 = clear
BBeam  in  1  raw back-beam sensor, asynchronous; 0 = broken, 1 = clear
full_flag  in  1  queue full, from the queue manager
empty_flag  in  1  queue empty, from the queue manager
up_count  out  1  to the queue manager; active-low single-cycle arrival pulse, idle 1
down_count  out  1  to the queue manager; active-low single-cycle departure pulse, idle 1
f_stuck  out  1  FBeam stuck-blocked fault, level
b_stuck  out  1  BBeam stuck-blocked fault, level

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - Both 2-FF synchroniser stages = 1.
  - Both FSMs = CLEAR; both counters = 0.
  - up_count = down_count = 1; f_stuck = b_stuck = 0.
- Channels: two identical, independent channels, B (BBeam to up_count) and F (FBeam to down_count). The stages below describe one channel; s is the second synchroniser FF output.
- Synchroniser: 2 flops per beam. A raw level is visible on s 2 edges after it is first sampled.
- FSM states: CLEAR, ARM_LOW, BLOCKED, ARM_HIGH, STUCK.
  - CLEAR: on s=0, go to ARM_LOW with cnt=1.
  - ARM_LOW, s=1: return to CLEAR with cnt=0. This is a glitch; no pulse.
  - ARM_LOW, s=0, cnt<DB_CYCLES: cnt increments.
  - ARM_LOW, s=0, cnt==DB_CYCLES: go to BLOCKED, cnt=0, fire the event.
  - BLOCKED, s=0: cnt increments, saturating. When cnt reaches STUCK_CYCLES, go to STUCK.
  - BLOCKED, s=1: go to ARM_HIGH with cnt=1.
  - ARM_HIGH, s=0: return to BLOCKED, keeping the BLOCKED count (held in a separate saturating dwell counter). No new event; this is release bounce.
  - ARM_HIGH, s=1, cnt==DB_CYCLES: go to CLEAR.
  - STUCK: stuck flag = 1. Needs DB_CYCLES consecutive s=1 samples (counted in cnt; any s=0 resets cnt to 0) to go to CLEAR. The stuck flag clears in the same cycle the FSM enters CLEAR.
- Event output: a fired event drives the registered output low for exactly one cycle, in the cycle the FSM is in BLOCKED for the first time.
- Latency: raw beam low, stable from edge k, produces the output low during the cycle after edge k+1+DB_CYCLES+1, i.e. 2+DB_CYCLES edges after first sample.
- One pulse per break: exactly one pulse per accepted break. Release never produces a pulse.
- Gating:
  - up_count is held at 1 (event dropped, not queued) if full_flag=1 in the cycle the event fires.
  - down_count is held at 1 if empty_flag=1 in that cycle.
  - Dropped events are not retried.
- Simultaneous events: F and B may pulse in the same cycle; both are issued unmodified.
- Reset mid-operation: all state returns to reset values. A beam still low after Reset deasserts is a new break and pulses after the normal latency, subject to gating.
- Counter arithmetic: all counters saturate; no wrap-around.

Test Plan:
- Defaults, Reset for 2 cycles; BBeam low 10 cycles then high 20 cycles; full_flag=0 -> up_count low for exactly 1 cycle, 6 edges after the first low sample; no further pulses; b_stuck stays 0.
- BBeam low 3 cycles then high -> up_count stays 1 throughout (glitch rejected); FSM back in CLEAR.
- BBeam sequence low 6, high 2, low 6, high 10 -> exactly one up_count pulse (release bounce ignored).
- FBeam low 10 cycles with empty_flag=1 -> down_count stays 1. Repeat with empty_flag=0 -> one down_count pulse. Same pair for BBeam/full_flag.
- FBeam and BBeam driven low on the same edge for 10 cycles -> up_count and down_count low in the same single cycle.
- BBeam low 80 cycles -> one up_count pulse, then b_stuck=1 from BLOCKED-count 64. Release -> b_stuck clears after 4 high samples. Next 10-cycle break -> one normal pulse.
- Assert Reset while BBeam is held low in BLOCKED, then release Reset -> outputs return to reset values; one new up_count pulse 6 edges after Reset deasserts.
